// File: rtl/pc_unit.sv
// ============================================================================
// pc_unit - program-counter stage feeding the instruction fetch unit.
//
// Holds the architectural PC and presents it to fetch every cycle. The next PC
// is chosen from the boot vector, a sequential increment, a stall hold or a
// branch/jump redirect. A three-state FSM (BOOT, RUN, HALT) sequences start-up
// and halting. A fetch counter reports how many PCs have been issued.
//
// Optional feature macro: PCU_MISALIGN_CHECK_EN
//   Defined   : a redirect whose target is not word aligned is refused. The PC
//               is held, the FSM enters HALT and PCU_misalign is set. The flag
//               stays set until reset.
//   Undefined : targets are taken as-is and PCU_misalign is tied low.
//
// Parameters
//   RESET_VECTOR  PC loaded on reset and held through BOOT
//   PC_STEP       byte increment per sequential fetch
//   CNT_W         fetch counter width
//
// Ports
//   PCU_clk        in   1      clock, rising edge
//   PCU_rst        in   1      asynchronous active-low reset
//   PCU_stall      in   1      hold current PC
//   PCU_redirect   in   1      load PCU_target on the next edge
//   PCU_target     in   32     redirect destination byte address
//   PCU_halt       in   1      enter HALT
//   PCU_resume     in   1      leave HALT at the held PC
//   PCU_PC         out  32     current PC (registered)
//   PCU_valid      out  1      PCU_PC is a live fetch request
//   PCU_fetch_cnt  out  CNT_W  number of PCs issued
//   PCU_misalign   out  1      sticky misaligned-target flag
// ============================================================================
module pc_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned PC_STEP      = 4,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             PCU_clk,
    input  logic             PCU_rst,
    input  logic             PCU_stall,
    input  logic             PCU_redirect,
    input  logic [31:0]      PCU_target,
    input  logic             PCU_halt,
    input  logic             PCU_resume,
    output logic [31:0]      PCU_PC,
    output logic             PCU_valid,
    output logic [CNT_W-1:0] PCU_fetch_cnt,
    output logic             PCU_misalign
);

    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    localparam logic [31:0] LP_STEP = 32'(PC_STEP);

    logic [1:0]       r_state;
    logic [31:0]      r_pc;
    logic [CNT_W-1:0] r_cnt;

    logic [1:0]       w_state_nxt;
    logic [31:0]      w_pc_nxt;
    logic             w_advance;
    logic             w_refuse;

    // Refusal only exists when the alignment check is built in.
`ifdef PCU_MISALIGN_CHECK_EN
    logic r_misalign;
    assign w_refuse = PCU_redirect && (PCU_target[1:0] != 2'b00);
`else
    assign w_refuse = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_advance   = 1'b0;
        case (r_state)
            S_BOOT: begin
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (PCU_halt) begin
                    w_state_nxt = S_HALT;
                end else if (PCU_redirect) begin
                    if (w_refuse) begin
                        w_state_nxt = S_HALT;
                    end else begin
                        w_pc_nxt  = PCU_target;
                        w_advance = 1'b1;
                    end
                end else if (!PCU_stall) begin
                    // 32-bit add wraps naturally at 2^32.
                    w_pc_nxt  = r_pc + LP_STEP;
                    w_advance = 1'b1;
                end
            end
            S_HALT: begin
                if (PCU_resume && !PCU_halt) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_BOOT;
                w_pc_nxt    = RESET_VECTOR;
            end
        endcase
    end

    always_ff @(posedge PCU_clk or negedge PCU_rst) begin
        if (!PCU_rst) begin
            r_state <= S_BOOT;
            r_pc    <= RESET_VECTOR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_advance) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

`ifdef PCU_MISALIGN_CHECK_EN
    always_ff @(posedge PCU_clk or negedge PCU_rst) begin
        if (!PCU_rst) begin
            r_misalign <= 1'b0;
        end else if ((r_state == S_RUN) && !PCU_halt && w_refuse) begin
            r_misalign <= 1'b1;
        end
    end
    assign PCU_misalign = r_misalign;
`else
    assign PCU_misalign = 1'b0;
`endif

    assign PCU_PC        = r_pc;
    assign PCU_valid     = (r_state == S_RUN);
    assign PCU_fetch_cnt = r_cnt;

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] target;
    logic        halt;
    logic        resume;
    logic [31:0] pc;
    logic        valid;
    logic [31:0] fetch_cnt;
    logic        misalign;

    int unsigned n_cmp;
    int unsigned n_mis;

    // Reference model: plain variables describing what the PC stage should show.
    bit          m_booting;
    bit          m_running;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    bit          m_misalign;

    pc_unit #(
        .RESET_VECTOR (32'h0000_0000),
        .PC_STEP      (4),
        .CNT_W        (32)
    ) dut (
        .PCU_clk       (clk),
        .PCU_rst       (rst_n),
        .PCU_stall     (stall),
        .PCU_redirect  (redirect),
        .PCU_target    (target),
        .PCU_halt      (halt),
        .PCU_resume    (resume),
        .PCU_PC        (pc),
        .PCU_valid     (valid),
        .PCU_fetch_cnt (fetch_cnt),
        .PCU_misalign  (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_all();
        chk("pc", 64'(pc), 64'(m_pc));
        chk("valid", 64'(valid), 64'(m_running));
        chk("cnt", 64'(fetch_cnt), 64'(m_cnt));
        chk("misalign", 64'(misalign), 64'(m_misalign));
    endtask

    function automatic bit target_refused(input logic [31:0] t);
`ifdef PCU_MISALIGN_CHECK_EN
        return (t % 4) != 0;
`else
        return 1'b0;
`endif
    endfunction

    // One clock edge of architectural behaviour, using the current inputs.
    task automatic model_edge();
        if (m_booting) begin
            m_booting = 0;
            m_running = 1;
        end else if (m_running) begin
            if (halt) begin
                m_running = 0;
            end else if (redirect) begin
                if (target_refused(target)) begin
                    m_running  = 0;
                    m_misalign = 1;
                end else begin
                    m_pc  = target;
                    m_cnt = m_cnt + 1;
                end
            end else if (!stall) begin
                m_pc  = 32'((64'(m_pc) + 4) % 64'h1_0000_0000);
                m_cnt = m_cnt + 1;
            end
        end else begin
            if (resume && !halt) m_running = 1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        m_booting  = 1;
        m_running  = 0;
        m_pc       = 32'h0;
        m_cnt      = 32'h0;
        m_misalign = 0;
        chk_all();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_all();
    endtask

    task automatic step(input logic st, input logic rd, input logic [31:0] tg,
                        input logic hl, input logic rs);
        stall    = st;
        redirect = rd;
        target   = tg;
        halt     = hl;
        resume   = rs;
        @(posedge clk);
        model_edge();
        #1;
        chk_all();
    endtask

    initial begin
        n_cmp    = 0;
        n_mis    = 0;
        rst_n    = 1'b1;
        stall    = 1'b0;
        redirect = 1'b0;
        target   = 32'h0;
        halt     = 1'b0;
        resume   = 1'b0;

        // Start-up: BOOT at 0 with valid low, then 0, 4, 8, C.
        do_reset();
        chk("boot_valid", 64'(valid), 64'd0);
        step(0, 0, 0, 0, 0);
        chk("run_pc0", 64'(pc), 64'h0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("pc_8", 64'(pc), 64'h8);
        // Stall three cycles at 8.
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
        chk("stall_pc", 64'(pc), 64'h8);
        chk("stall_cnt", 64'(fetch_cnt), 64'd2);
        step(0, 0, 0, 0, 0);
        chk("pc_c", 64'(pc), 64'hC);
        chk("cnt_3", 64'(fetch_cnt), 64'd3);

        // Redirect beats stall.
        step(1, 1, 32'h40, 0, 0);
        chk("redir_pc", 64'(pc), 64'h40);
        step(0, 0, 0, 0, 0);
        chk("redir_next", 64'(pc), 64'h44);

        // Wrap at top of address space.
        step(0, 1, 32'hFFFF_FFFC, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("wrap_pc", 64'(pc), 64'h0);

        // Halt at 0x10; redirect/stall ignored, halt+resume stays halted.
        step(0, 1, 32'h10, 0, 0);
        step(0, 0, 0, 1, 0);
        chk("halt_valid", 64'(valid), 64'd0);
        chk("halt_pc", 64'(pc), 64'h10);
        step(1, 1, 32'h80, 0, 0);
        step(0, 0, 0, 1, 1);
        chk("halt_hold", 64'(pc), 64'h10);
        step(0, 0, 0, 0, 1);
        chk("resume_valid", 64'(valid), 64'd1);
        step(0, 0, 0, 0, 0);
        chk("resume_next", 64'(pc), 64'h14);

        // Misaligned redirect: refused with the check built in, taken otherwise.
        step(0, 1, 32'h42, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);

        // Mid-operation reset discards everything.
        do_reset();
        chk("rst_misalign", 64'(misalign), 64'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] t;
            int unsigned r;
            if ($urandom_range(399) == 0) begin
                do_reset();
            end else begin
                r = $urandom_range(15);
                if (r == 0)      t = 32'hFFFF_FFFC;
                else if (r < 4)  t = $urandom();
                else             t = $urandom() & 32'hFFFF_FFFC;
                step(($urandom_range(9) < 3), ($urandom_range(19) < 3), t,
                     ($urandom_range(19) == 0), ($urandom_range(9) < 3));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
